multi_pulse_generator: RTL and testbench

Parametrised, multi-channel successor to the single-channel tick pulse generator: CH independent channels, each with its own period, pulse width and mode (free-running periodic or triggered one-shot). Sits next to the timing/strobe logic and drives enables, PWM-style outputs and timeout strobes. Configuration is shadowed and updated only at period boundaries, so outputs never glitch mid-period. A shared `sync` input phase-aligns all running channels.

---
 rtl/multi_pulse_generator_if.sv | 30 +++
 rtl/multi_pulse_generator.sv | 93 +++++++++
 tb/tb_multi_pulse_generator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_pulse_generator_if.sv
// Control/status bundle for multi_pulse_generator: per-channel config and
// triggers in, pulse/busy/done status out.
interface multi_pulse_generator_if #(
    parameter int N  = 8,
    parameter int CH = 4
);
    // Handshake: start[i] is a sampled request with no ready; it is accepted
    // on an edge where the channel is IDLE, in one-shot mode, enabled and ena=1,
    // and acceptance is visible as busy[i]=1 in the following cycle.
    logic              ena;
    logic              sync;
    logic [CH-1:0]     chan_en;
    logic [CH-1:0]     mode;
    logic [CH-1:0]     start;
    logic [CH*N-1:0]   ticks;
    logic [CH*N-1:0]   width;
    logic [CH-1:0]     out;
    logic [CH-1:0]     busy;
    logic [CH-1:0]     done;

    modport master (
        output ena, sync, chan_en, mode, start, ticks, width,
        input  out, busy, done
    );

    modport slave (
        input  ena, sync, chan_en, mode, start, ticks, width,
        output out, busy, done
    );
endinterface

// File: rtl/multi_pulse_generator.sv
// CH independent periodic / one-shot pulse channels with period-boundary
// shadowed configuration and a shared phase-align (sync) input.
module multi_pulse_generator #(
    parameter int N  = 8,
    parameter int CH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_pulse_generator_if.slave bus,
    output logic [CH-1:0]         state_dbg
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [CH-1:0] out_v;
    logic [CH-1:0] busy_v;
    logic [CH-1:0] done_v;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t       state;
        logic [N-1:0] cnt;
        logic [N-1:0] p_sh;
        logic [N-1:0] w_sh;
        logic         one_shot;
        logic         done_q;
        logic [N-1:0] tk;
        logic [N-1:0] wd;

        assign tk = bus.ticks[i*N +: N];
        assign wd = bus.width[i*N +: N];

        always_ff @(posedge clk) begin
            if (!rst) begin
                state    <= IDLE;
                cnt      <= '0;
                p_sh     <= '0;
                w_sh     <= '0;
                one_shot <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                case (state)
                    IDLE: begin
                        // Mode is captured here so a mid-run mode change waits for IDLE.
                        if (bus.ena && bus.chan_en[i] && (tk != '0) &&
                            (!bus.mode[i] || bus.start[i])) begin
                            state    <= RUN;
                            cnt      <= '0;
                            p_sh     <= tk;
                            w_sh     <= wd;
                            one_shot <= bus.mode[i];
                        end
                    end
                    RUN: begin
                        if (!bus.chan_en[i]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (bus.sync) begin
                            // A zero period on reload cannot run, same as at a wrap.
                            cnt  <= '0;
                            p_sh <= tk;
                            w_sh <= wd;
                            if (tk == '0) state <= IDLE;
                        end else if (bus.ena) begin
                            if (cnt == p_sh - N'(1)) begin
                                cnt <= '0;
                                if (one_shot) begin
                                    state  <= IDLE;
                                    done_q <= 1'b1;
                                end else begin
                                    p_sh <= tk;
                                    w_sh <= wd;
                                    if (tk == '0) state <= IDLE;
                                end
                            end else begin
                                cnt <= cnt + N'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign out_v[i]     = (state == RUN) && (cnt < w_sh);
        assign busy_v[i]    = (state == RUN);
        assign done_v[i]    = done_q;
        assign state_dbg[i] = (state == RUN);
    end

    assign bus.out  = out_v;
    assign bus.busy = busy_v;
    assign bus.done = done_v;
endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed + randomized bench for multi_pulse_generator against a per-channel
// position/period reference model.
module tb_multi_pulse_generator;
    localparam int N  = 8;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] state_dbg;

    multi_pulse_generator_if #(.N(N), .CH(CH)) bus ();

    multi_pulse_generator #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;

    bit m_run [CH];
    int m_pos [CH];
    int m_per [CH];
    int m_wid [CH];
    bit m_os  [CH];
    bit m_dn  [CH];

    function automatic logic [CH-1:0] exp_out();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = m_run[i] && (m_pos[i] < m_wid[i]);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_busy();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = m_run[i];
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_done();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = m_dn[i];
        return r;
    endfunction

    // Advance every channel by one clock edge using the inputs present at it.
    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            int tk;
            int wd;
            tk = int'(bus.ticks[i*N +: N]);
            wd = int'(bus.width[i*N +: N]);
            m_dn[i] = 1'b0;
            if (!rst) begin
                m_run[i] = 1'b0; m_pos[i] = 0; m_per[i] = 0; m_wid[i] = 0; m_os[i] = 1'b0;
            end else if (!m_run[i]) begin
                if (bus.ena && bus.chan_en[i] && tk != 0 && (!bus.mode[i] || bus.start[i])) begin
                    m_run[i] = 1'b1; m_pos[i] = 0; m_per[i] = tk; m_wid[i] = wd; m_os[i] = bus.mode[i];
                end
            end else if (!bus.chan_en[i]) begin
                m_run[i] = 1'b0; m_pos[i] = 0;
            end else if (bus.sync) begin
                m_pos[i] = 0; m_per[i] = tk; m_wid[i] = wd;
                if (tk == 0) m_run[i] = 1'b0;
            end else if (bus.ena) begin
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] == m_per[i]) begin
                    m_pos[i] = 0;
                    if (m_os[i]) begin
                        m_run[i] = 1'b0;
                        m_dn[i]  = 1'b1;
                    end else begin
                        m_per[i] = tk; m_wid[i] = wd;
                        if (tk == 0) m_run[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_out",  32'(bus.out),   32'(exp_out()));
        chk("model_busy", 32'(bus.busy),  32'(exp_busy()));
        chk("model_done", 32'(bus.done),  32'(exp_done()));
        chk("model_state", 32'(state_dbg), 32'(exp_busy()));
    endtask

    task automatic set_cfg(input int ch, input int p, input int w);
        bus.ticks[ch*N +: N] = N'(p);
        bus.width[ch*N +: N] = N'(w);
    endtask

    task automatic run_pat(input int w, input logic [7:0] expv, input string tag);
        logic [7:0] pat;
        bus.chan_en[0] = 1'b0;
        step();
        set_cfg(0, 4, w);
        bus.chan_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            pat[k] = bus.out[0];
        end
        chk(tag, 32'(pat), 32'(expv));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] pat16;
        logic [7:0]  ob, bb, db;

        bus.ena = 1'b0; bus.sync = 1'b0; bus.chan_en = '0; bus.mode = '0;
        bus.start = '0; bus.ticks = '0; bus.width = '0;
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 1'b0; m_pos[i] = 0; m_per[i] = 0; m_wid[i] = 0; m_os[i] = 1'b0; m_dn[i] = 1'b0;
        end

        // Reset held with random inputs
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.ena = 1'($urandom); bus.sync = 1'($urandom); bus.chan_en = CH'($urandom);
            bus.mode = CH'($urandom); bus.start = CH'($urandom);
            bus.ticks = (CH*N)'($urandom); bus.width = (CH*N)'($urandom);
            step();
            chk("rst_out", 32'(bus.out), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b1;
        bus.chan_en = '0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("idle_out", 32'(bus.out), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        bus.ena = 1'b1; bus.sync = 1'b0; bus.mode = '0; bus.start = '0;
        bus.ticks = '0; bus.width = '0;

        // Periodic baseline on ch0, P=4
        run_pat(1, 8'b0001_0001, "p4_w1");
        run_pat(3, 8'b0111_0111, "p4_w3");
        run_pat(0, 8'b0000_0000, "p4_w0");
        run_pat(7, 8'b1111_1111, "p4_w7");
        bus.chan_en[0] = 1'b0;
        step();

        // Shadowing on ch1: reconfigure at cnt=2
        set_cfg(1, 5, 2);
        bus.chan_en[1] = 1'b1;
        pat16 = '0;
        for (int k = 0; k < 11; k++) begin
            step();
            pat16[k] = bus.out[1];
            if (k == 2) set_cfg(1, 3, 1);
        end
        chk("shadow", 32'(pat16), 32'h0123);
        bus.chan_en[1] = 1'b0;
        step();

        // One-shot on ch2: mid-run start ignored, retrigger on done cycle
        set_cfg(2, 6, 2);
        bus.mode[2] = 1'b1;
        bus.chan_en[2] = 1'b1;
        bus.start[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            ob[k] = bus.out[2]; bb[k] = bus.busy[2]; db[k] = bus.done[2];
            if (k == 0) bus.start[2] = 1'b0;
            if (k == 1) bus.start[2] = 1'b1;
            if (k == 2) bus.start[2] = 1'b0;
            if (k == 6) bus.start[2] = 1'b1;
            if (k == 7) bus.start[2] = 1'b0;
        end
        chk("os_out", 32'(ob), 32'h83);
        chk("os_busy", 32'(bb), 32'hBF);
        chk("os_done", 32'(db), 32'h40);

        // Abort the retriggered one-shot mid-run
        step();
        step();
        bus.chan_en[2] = 1'b0;
        step();
        chk("abort_busy", 32'(bus.busy[2]), 32'd0);
        chk("abort_done", 32'(bus.done[2]), 32'd0);
        step();
        chk("abort_done2", 32'(bus.done[2]), 32'd0);
        bus.mode[2] = 1'b0;

        // Stall and sync on ch0 (P=4,W=2) and ch1 (P=6,W=3)
        set_cfg(0, 4, 2);
        set_cfg(1, 6, 3);
        bus.chan_en[1:0] = 2'b11;
        for (int k = 0; k < 3; k++) step();
        bus.ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_out", 32'(bus.out[1:0]), 32'b10);
        end
        bus.ena = 1'b1;
        bus.sync = 1'b1;
        step();
        chk("sync_out", 32'(bus.out[1:0]), 32'b11);
        chk("sync_busy", 32'(bus.busy[1:0]), 32'b11);
        bus.sync = 1'b0;
        step();

        // Reset mid-period
        rst = 1'b0;
        step();
        chk("midrst_out", 32'(bus.out), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        rst = 1'b1;

        // Zero period never starts
        bus.chan_en = 4'b1000;
        set_cfg(3, 0, 3);
        for (int k = 0; k < 3; k++) step();
        chk("p0_busy", 32'(bus.busy[3]), 32'd0);
        bus.chan_en = '0;
        step();

        // Randomized traffic
        for (int i = 0; i < CH; i++) set_cfg(i, $urandom_range(1, 7), $urandom_range(0, 9));
        bus.chan_en = '1;
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 79) != 0);
            bus.ena  = ($urandom_range(0, 5) != 0);
            bus.sync = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) bus.chan_en = CH'($urandom);
            if ($urandom_range(0, 7) == 0) bus.mode = CH'($urandom);
            bus.start = CH'($urandom);
            if ($urandom_range(0, 4) == 0)
                set_cfg($urandom_range(0, CH-1), $urandom_range(0, 7), $urandom_range(0, 9));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
